// File: rtl/core_pkg.sv
// Shared core types for the memory stage: funct3 encodings, write-back
// record, load/store FSM states, byte-enable constants and lane helpers.
package core_pkg;

    typedef enum logic [2:0] {
        LS_BYTE       = 3'b000,
        LS_HALFWORD   = 3'b001,
        LS_WORD       = 3'b010,
        LS_BYTE_U     = 3'b100,
        LS_HALFWORD_U = 3'b101
    } load_store_funct3_t;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
    } write_back_t;

    typedef enum logic [1:0] {
        LSU_IDLE     = 2'd0,
        LSU_REQ      = 2'd1,
        LSU_WAIT_RSP = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Access size depends only on funct3[1:0]; undefined codes fall to word.
    function automatic lsu_size_t lsu_size(input logic [2:0] funct3);
        lsu_size_t sz;
        case (funct3[1:0])
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Store byte enables; halfwords ignore off[0], words ignore off.
    function automatic logic [3:0] lsu_store_be(input lsu_size_t sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = BE_BYTE << off;
            SZ_HALF: be = BE_HALF << {off[1], 1'b0};
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

    // Store data replicated across lanes so the byte enables pick the right one.
    function automatic logic [31:0] lsu_store_lanes(input lsu_size_t sz, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (sz)
            SZ_BYTE: lanes = {4{wdata[7:0]}};
            SZ_HALF: lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_load_aligner.sv
// Combinational load-data extractor: selects the addressed byte/halfword
// from a 32-bit memory word and sign- or zero-extends it.
module lsu_load_aligner
    import core_pkg::*;
(
    input  logic [31:0] mem_rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        signed_s;

    // Lane select and extension by access size; funct3[2] marks the unsigned variants.
    always_comb begin
        byte_s   = mem_rdata_i[{off_i, 3'b000} +: 8];
        half_s   = off_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        signed_s = ~funct3_i[2];
        data_o   = mem_rdata_i;
        case (lsu_size(funct3_i))
            SZ_BYTE: data_o = {{24{signed_s & byte_s[7]}}, byte_s};
            SZ_HALF: data_o = {{16{signed_s & half_s[15]}}, half_s};
            default: data_o = mem_rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: accepts one load/store at a time, issues it on a
// single-outstanding valid/ready memory port and returns extended load data
// as a one-cycle write_back_t.
// Optional build macro LSU_MISALIGN_CHECK_EN: misaligned halfword/word ops are
// dropped without a memory request and flagged on the misaligned pulse.
module load_store_unit
    import core_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata,
    output write_back_t       wb,
    output logic              store_done,
    output logic              misaligned
);

    lsu_state_t        state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              store_done_q, store_done_d;
    write_back_t       wb_q, wb_d;
    logic [31:0]       aligned_s;
    lsu_size_t         req_size_s;
    logic              req_ready_s;
    logic              req_misaligned_s;

    lsu_load_aligner u_aligner (
        .mem_rdata_i (mem_rdata),
        .funct3_i    (funct3_q),
        .off_i       (off_q),
        .data_o      (aligned_s)
    );

    assign req_size_s = lsu_size(req_funct3);

`ifdef LSU_MISALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;

    // The cycle spent flagging a dropped op is a busy cycle.
    assign req_ready_s      = (state_q == LSU_IDLE) && !misaligned_q;
    assign req_misaligned_s = ((req_size_s == SZ_HALF) && req_addr[0]) ||
                              ((req_size_s == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign misaligned       = misaligned_q;

    // Misalignment pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`else
    assign req_ready_s      = (state_q == LSU_IDLE);
    assign req_misaligned_s = 1'b0;
    assign misaligned       = 1'b0;
`endif

    assign req_ready     = req_ready_s;
    assign mem_req_valid = (state_q == LSU_REQ);
    assign mem_we        = is_store_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_be        = mem_be_q;
    assign wb            = wb_q;
    assign store_done    = store_done_q;

    // State and datapath registers; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LSU_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0000_0000;
            store_done_q <= 1'b0;
            wb_q         <= '0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            store_done_q <= store_done_d;
            wb_q         <= wb_d;
        end
    end

    // Next-state and datapath update; pulses default low, held values default to current.
    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        store_done_d = 1'b0;
        wb_d         = '{data: wb_q.data, valid: 1'b0};
`ifdef LSU_MISALIGN_CHECK_EN
        misaligned_d = 1'b0;
`endif
        case (state_q)
            LSU_IDLE: begin
                if (req_valid && req_ready_s) begin
                    is_store_d  = req_is_store;
                    funct3_d    = req_funct3;
                    off_d       = req_addr[1:0];
                    mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                    mem_be_d    = req_is_store ? lsu_store_be(req_size_s, req_addr[1:0]) : 4'b0000;
                    mem_wdata_d = lsu_store_lanes(req_size_s, req_wdata);
                    if (req_misaligned_s) begin
`ifdef LSU_MISALIGN_CHECK_EN
                        misaligned_d = 1'b1;
`endif
                        state_d = LSU_IDLE;
                    end else begin
                        state_d = LSU_REQ;
                    end
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_REQ: begin
                if (mem_req_ready) begin
                    if (is_store_q) begin
                        store_done_d = 1'b1;
                        state_d      = LSU_IDLE;
                    end else begin
                        state_d = LSU_WAIT_RSP;
                    end
                end else begin
                    state_d = LSU_REQ;
                end
            end
            LSU_WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    wb_d    = '{data: aligned_s, valid: 1'b1};
                    state_d = LSU_IDLE;
                end else begin
                    state_d = LSU_WAIT_RSP;
                end
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, reset-in-flight
// sequence and randomized ops checked against a byte-level reference model.
module tb_load_store_unit;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    write_back_t wb;
    logic        store_done;
    logic        misaligned;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          stall;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_wb;
    } vec_t;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_store  (req_is_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .wb            (wb),
        .store_done    (store_done),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte-level arithmetic on the access size and offset.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int off;
        int nbytes;
        logic [31:0] x;
        r      = v;
        off    = int'(v.addr[1:0]);
        nbytes = 4;
        if (v.f3 == 3'd0 || v.f3 == 3'd4) nbytes = 1;
        if (v.f3 == 3'd1 || v.f3 == 3'd5) nbytes = 2;
        r.e_addr = v.addr & 32'hFFFF_FFFC;
        if (nbytes == 1) begin
            r.e_be    = 4'(32'd1 << off);
            r.e_wdata = (v.wdata & 32'h0000_00FF) * 32'h0101_0101;
            x         = (v.rdata >> (8 * off)) & 32'h0000_00FF;
            r.e_wb    = (v.f3 == 3'd0 && x >= 32'd128) ? (x | 32'hFFFF_FF00) : x;
        end else if (nbytes == 2) begin
            off       = (off / 2) * 2;
            r.e_be    = 4'(32'd3 << off);
            r.e_wdata = (v.wdata & 32'h0000_FFFF) * 32'h0001_0001;
            x         = (v.rdata >> (8 * off)) & 32'h0000_FFFF;
            r.e_wb    = (v.f3 == 3'd1 && x >= 32'd32768) ? (x | 32'hFFFF_0000) : x;
        end else begin
            r.e_be    = 4'b1111;
            r.e_wdata = v.wdata;
            r.e_wb    = v.rdata;
        end
        return r;
    endfunction

    function automatic bit is_misaligned(input vec_t v);
        int nbytes;
        nbytes = 4;
        if (v.f3 == 3'd0 || v.f3 == 3'd4) nbytes = 1;
        if (v.f3 == 3'd1 || v.f3 == 3'd5) nbytes = 2;
        return (int'(v.addr[1:0]) % nbytes) != 0;
    endfunction

    // Runs one op from a negedge; stalls mem_req_ready for v.stall cycles.
    task automatic run_op(input vec_t v);
        req_valid    = 1'b1;
        req_is_store = v.st;
        req_funct3   = v.f3;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        chk("misaligned_low", 32'(misaligned), 32'd0);
        for (int i = 0; i <= v.stall; i++) begin
            chk("mem_req_valid", 32'(mem_req_valid), 32'd1);
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            chk("mem_addr", mem_addr, v.e_addr);
            chk("mem_we", 32'(mem_we), 32'(v.st));
            if (v.st) begin
                chk("mem_be", 32'(mem_be), 32'(v.e_be));
                chk("mem_wdata", mem_wdata, v.e_wdata);
            end
            mem_req_ready = (i == v.stall);
            mem_rsp_valid = (i < v.stall);
            mem_rdata     = $urandom;
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        if (v.st) begin
            chk("store_done_pulse", 32'(store_done), 32'd1);
            chk("store_wb_valid", 32'(wb.valid), 32'd0);
            chk("store_req_ready", 32'(req_ready), 32'd1);
            chk("store_mem_req_valid", 32'(mem_req_valid), 32'd0);
            @(negedge clk);
            chk("store_done_end", 32'(store_done), 32'd0);
        end else begin
            chk("load_mem_req_valid", 32'(mem_req_valid), 32'd0);
            chk("load_store_done", 32'(store_done), 32'd0);
            chk("load_wb_early", 32'(wb.valid), 32'd0);
            mem_rsp_valid = 1'b1;
            mem_rdata     = v.rdata;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rdata     = $urandom;
            chk("wb_valid", 32'(wb.valid), 32'd1);
            chk("wb_data", wb.data, v.e_wb);
            @(negedge clk);
            chk("wb_valid_end", 32'(wb.valid), 32'd0);
            chk("wb_data_hold", wb.data, v.e_wb);
            chk("load_req_ready", 32'(req_ready), 32'd1);
        end
    endtask

    // Misaligned op under the check feature: no request, one misaligned pulse.
    task automatic run_misaligned(input vec_t v);
        req_valid    = 1'b1;
        req_is_store = v.st;
        req_funct3   = v.f3;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mis_pulse", 32'(misaligned), 32'd1);
        chk("mis_no_req", 32'(mem_req_valid), 32'd0);
        chk("mis_wb_valid", 32'(wb.valid), 32'd0);
        @(negedge clk);
        chk("mis_pulse_end", 32'(misaligned), 32'd0);
        chk("mis_no_req2", 32'(mem_req_valid), 32'd0);
        chk("mis_req_ready", 32'(req_ready), 32'd1);
        chk("mis_wb_valid2", 32'(wb.valid), 32'd0);
    endtask

    task automatic dispatch(input vec_t v);
`ifdef LSU_MISALIGN_CHECK_EN
        if (is_misaligned(v)) run_misaligned(v);
        else run_op(v);
`else
        run_op(v);
`endif
    endtask

    vec_t tbl[11];

    initial begin
        vec_t v;
        // st, f3, addr, wdata, rdata, stall, e_addr, e_be, e_wdata, e_wb
        tbl[0]  = '{1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0};
        tbl[1]  = '{1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_F000, 0, 32'h0000_2000, 4'b0000, 32'h0, 32'hFFFF_FFF0};
        tbl[2]  = '{1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_F000, 0, 32'h0000_2000, 4'b0000, 32'h0, 32'h0000_00F0};
        tbl[3]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 3, 32'h0000_2000, 4'b0000, 32'h0, 32'h0000_8001};
        tbl[4]  = '{1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'hDEAD_BEEF, 0, 32'h0000_3000, 4'b0000, 32'h0, 32'hDEAD_BEEF};
        tbl[5]  = '{1'b1, 3'b001, 32'h0000_4003, 32'h1234_ABCD, 32'h0, 1, 32'h0000_4000, 4'b1100, 32'hABCD_ABCD, 32'h0};
        tbl[6]  = '{1'b1, 3'b010, 32'h0000_5001, 32'h1122_3344, 32'h0, 0, 32'h0000_5000, 4'b1111, 32'h1122_3344, 32'h0};
        tbl[7]  = '{1'b0, 3'b001, 32'h0000_6000, 32'h0, 32'h1234_8765, 2, 32'h0000_6000, 4'b0000, 32'h0, 32'hFFFF_8765};
        tbl[8]  = '{1'b0, 3'b011, 32'h0000_7004, 32'h0, 32'hCAFE_F00D, 0, 32'h0000_7004, 4'b0000, 32'h0, 32'hCAFE_F00D};
        tbl[9]  = '{1'b1, 3'b101, 32'h0000_8002, 32'h0000_BEEF, 32'h0, 0, 32'h0000_8000, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        tbl[10] = '{1'b1, 3'b100, 32'h0000_8001, 32'h0000_0012, 32'h0, 0, 32'h0000_8000, 4'b0010, 32'h1212_1212, 32'h0};

        rst           = 1'b1;
        req_valid     = 1'b0;
        req_is_store  = 1'b0;
        req_funct3    = 3'b000;
        req_addr      = 32'h0;
        req_wdata     = 32'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_wb", {wb.data[30:0], wb.valid}, 32'h0);
        chk("rst_store_done", 32'(store_done), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 11; i++) dispatch(tbl[i]);

        // Reset while waiting for a load response; the late response is ignored.
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct3   = 3'b010;
        req_addr     = 32'h0000_9000;
        @(negedge clk);
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("wait_rsp_busy", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h5555_AAAA;
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_wb_valid", 32'(wb.valid), 32'd0);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("rst_mid_ignored", 32'(wb.valid), 32'd0);
        chk("rst_mid_wb_data", wb.data, 32'h0);
        chk("rst_mid_no_req", 32'(mem_req_valid), 32'd0);
        dispatch(tbl[1]);

        // Randomized ops against the reference model.
        for (int n = 0; n < 60; n++) begin
            v.st    = 1'($urandom_range(1, 0));
            v.f3    = 3'($urandom_range(7, 0));
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.stall = $urandom_range(2, 0);
            v       = model(v);
            dispatch(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
